host_mem_arbiter: RTL and testbench
===================================

// Module: host_mem_arbiter
// PURPOSE
//  N-to-1 OBI arbiter feeding the single host memory slave port. Accepts OBI requests from
//  N masters (host CPU, e-GPU host-side loader, ...), serialises them onto one OBI request
//  channel and routes each response back to its originating master.
//  Holds in-order outstanding-transaction IDs in a small FIFO.
// PARAMETERS
//  N_MASTERS      2   number of upstream OBI masters (>=2)
//  OUTST_DEPTH    2   max outstanding granted-but-unanswered transactions (power of 2, >=1)
// PORTS
//  clk_i        in   1            clock
//  rst_i        in   1            synchronous, active-high reset
//  m_req_i      in   N            per-master request
//  m_we_i       in   N            per-master write enable
//  m_be_i       in   N x 4        per-master byte enables
//  m_addr_i     in   N x 32       per-master byte address
//  m_wdata_i    in   N x 32       per-master write data
//  m_gnt_o      out  N            per-master grant (one-hot or zero)
//  m_rvalid_o   out  N            per-master response valid (one-hot or zero)
//  m_rdata_o    out  32           response data, broadcast to all masters
//  s_req_o      out  1            request to host memory
//  s_we_o/s_be_o/s_addr_o/s_wdata_o  out 1/4/32/32  muxed request payload
//  s_gnt_i      in   1            grant from host memory
//  s_rvalid_i   in   1            response valid from host memory
//  s_rdata_i    in   32           response data from host memory
//  err_o        out  1            sticky: s_rvalid_i seen with no outstanding ID
// BEHAVIOUR
//  - Reset (rst_i=1 at clk edge): rr pointer=0, lock=0, ID FIFO empty, err_o=0.
//    All outputs combinationally 0 while no master requests.
//  - Arbitration: round-robin over m_req_i starting at rr pointer; winner sel drives s_* payload.
//    s_req_o = (|m_req_i) & ~fifo_full. Zero added latency on request path (combinational mux).
//  - Lock: if s_req_o=1 and s_gnt_i=0, register sel and lock=1. While locked, sel is frozen
//    (OBI: req/payload stable until gnt) regardless of other masters. Lock clears on gnt.
//  - Handshake (s_req_o & s_gnt_i): m_gnt_o[sel]=1 same cycle. Push sel into ID FIFO.
//    rr pointer <= (sel+1) mod N.
//  - Response: s_rvalid_i=1 -> pop FIFO head h; m_rvalid_o[h]=1, m_rdata_o=s_rdata_i same
//    cycle. Write responses routed identically (rdata don't-care).
//  - Simultaneous push+pop: both happen, occupancy unchanged. Allowed when FIFO full
//    (pop frees slot, but s_req_o still gated by registered full flag -> no push that cycle).
//  - Full: s_req_o=0, no m_gnt_o; masters wait with req held.
//  - Empty + s_rvalid_i: response dropped, no m_rvalid_o, err_o<=1 until reset.
//  - No master requesting: s_req_o=0, rr pointer and lock unchanged.
//  - Reset mid-transaction: outstanding IDs discarded; slave and masters share rst_i,
//    so late responses are not expected; if one arrives, err_o sets.
//  - Ordering: responses strictly in grant order (slave is in-order).
// CONFIGURATION
//  HOST_MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr pointer unused.
//    Lock behaviour unchanged.
//  Undefined (default): round-robin as above.
// STRUCTURE
//  host_mem_arb_pkg: OBI_AW=32, OBI_DW=32, OBI_BEW=4 constants; id_t = logic[$clog2(N_MASTERS)-1:0]
//    (width passed as param); arb_state_t {ARB_FREE, ARB_LOCKED}.
//  Sub-module host_mem_arb_id_fifo: sync FIFO of id_t, depth OUTST_DEPTH, push/pop/full/empty,
//    head output combinational, simultaneous push/pop legal.
// TESTING
//  1 Reset, m_req_i=2'b01 read addr 0x100, 1-cycle gnt, rvalid next cycle rdata 0xDEADBEEF
//    -> m_gnt_o=01, then m_rvalid_o=01, m_rdata_o=0xDEADBEEF.
//  2 Both masters request every cycle (RR build) -> grants alternate 01,10,01,10;
//    rvalids follow the same sequence.
//  3 Master1 req with s_gnt_i held 0 for 3 cycles while master0 raises req
//    -> s_addr_o stays master1 addr, m_gnt_o=10 when gnt arrives.
//  4 OUTST_DEPTH=2, slave grants 2 without responding -> 3rd request: s_req_o=0;
//    after one rvalid, next request granted.
//  5 s_rvalid_i=1 with FIFO empty -> no m_rvalid_o, err_o=1 and stays 1 until rst_i.
//  6 Build with HOST_MEM_ARB_FIXED_PRIO_EN, both request continuously
//    -> m_gnt_o=01 every grant; master1 starved.

Source files
------------

// File: rtl/host_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// host_mem_arb_pkg
// Shared constants and types for the host memory OBI arbiter.
//   OBI_AW / OBI_DW / OBI_BEW : OBI address, data and byte-enable widths
//   arb_state_t               : request-path state (free to arbitrate, or
//                               locked onto a master awaiting grant)
//   id_width()                : width of a master index; at least 1 bit so
//                               degenerate configurations stay legal
// The master-ID type itself depends on N_MASTERS, so each module declares
// it locally as logic [id_width(N_MASTERS)-1:0].
// -----------------------------------------------------------------------------
package host_mem_arb_pkg;

  localparam int OBI_AW  = 32;
  localparam int OBI_DW  = 32;
  localparam int OBI_BEW = 4;

  typedef enum logic [0:0] {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int id_width(input int n_masters);
    return (n_masters > 1) ? $clog2(n_masters) : 1;
  endfunction

endpackage : host_mem_arb_pkg

// File: rtl/host_mem_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// host_mem_arb_id_fifo
// Synchronous FIFO holding the master index of every granted-but-unanswered
// OBI transaction, in grant order. The head is combinational so a response
// can be routed in the same cycle it arrives.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i         enqueue push_id_i (ignored while full)
//   push_id_i      master index to enqueue
//   pop_i          dequeue the head (ignored while empty)
//   head_o         oldest stored index (undefined while empty)
//   full_o         DEPTH entries stored
//   empty_o        no entries stored
// Push and pop in the same cycle are both performed; occupancy is unchanged.
// -----------------------------------------------------------------------------
module host_mem_arb_id_fifo #(
  parameter int ID_W  = 1,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap explicitly so any DEPTH works, not only powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? {PTR_W{1'b0}} : (p + PTR_W'(32'd1));
  endfunction

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(32'd1);
      2'b01:   cnt_d = cnt_q - CNT_W'(32'd1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

endmodule : host_mem_arb_id_fifo

// File: rtl/host_mem_arbiter.sv
// -----------------------------------------------------------------------------
// host_mem_arbiter
// N-to-1 OBI arbiter in front of the single host memory slave port. Requests
// from N masters are serialised onto one OBI request channel with zero added
// latency; each response is routed back to the master that issued it using an
// in-order FIFO of outstanding master indices.
//
// Parameters:
//   N_MASTERS    number of upstream OBI masters (>= 2)
//   OUTST_DEPTH  maximum granted-but-unanswered transactions (>= 1)
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   m_req_i/m_we_i            per-master request / write enable (N bits)
//   m_be_i                    per-master byte enables, master i at [4*i +: 4]
//   m_addr_i/m_wdata_i        per-master address / write data, master i at [32*i +: 32]
//   m_gnt_o                   per-master grant, one-hot or zero
//   m_rvalid_o                per-master response valid, one-hot or zero
//   m_rdata_o                 response data, broadcast to all masters
//   s_req_o/s_we_o/s_be_o/s_addr_o/s_wdata_o  request towards host memory
//   s_gnt_i/s_rvalid_i/s_rdata_i              grant and response from host memory
//   err_o                     sticky: a response arrived with nothing outstanding
//
// Build option:
//   HOST_MEM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                               undefined -> round-robin from a rotating pointer
// In both builds a request left waiting for s_gnt_i locks the selection so
// the OBI payload stays stable until it is granted.
// -----------------------------------------------------------------------------
module host_mem_arbiter
  import host_mem_arb_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int OUTST_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_MASTERS-1:0]          m_req_i,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS*OBI_BEW-1:0]  m_be_i,
  input  logic [N_MASTERS*OBI_AW-1:0]   m_addr_i,
  input  logic [N_MASTERS*OBI_DW-1:0]   m_wdata_i,
  output logic [N_MASTERS-1:0]          m_gnt_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic [OBI_DW-1:0]             m_rdata_o,
  output logic                          s_req_o,
  output logic                          s_we_o,
  output logic [OBI_BEW-1:0]            s_be_o,
  output logic [OBI_AW-1:0]             s_addr_o,
  output logic [OBI_DW-1:0]             s_wdata_o,
  input  logic                          s_gnt_i,
  input  logic                          s_rvalid_i,
  input  logic [OBI_DW-1:0]             s_rdata_i,
  output logic                          err_o
);

  localparam int ID_W = id_width(N_MASTERS);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] sel_q, sel_d;
  logic [ID_W-1:0] arb_pick_s;
  logic [ID_W-1:0] sel_s;
  logic            any_req_s;
  logic            hs_s;
  logic            rsp_ok_s;
  logic            err_q, err_d;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [ID_W-1:0] fifo_head_s;

  assign any_req_s = |m_req_i;

`ifdef HOST_MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requesting index is kept last.
  always_comb begin
    arb_pick_s = {ID_W{1'b0}};
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      arb_pick_s = m_req_i[i] ? ID_W'(i) : arb_pick_s;
    end
  end
`else
  logic [ID_W-1:0] rr_q, rr_d;
  logic            rr_found_s;

  // Round-robin: first requester found walking upward from the pointer, wrapping.
  always_comb begin
    arb_pick_s = {ID_W{1'b0}};
    rr_found_s = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      arb_pick_s = (!rr_found_s && m_req_i[(int'(rr_q) + i) % N_MASTERS])
                   ? ID_W'((int'(rr_q) + i) % N_MASTERS) : arb_pick_s;
      rr_found_s = rr_found_s | m_req_i[(int'(rr_q) + i) % N_MASTERS];
    end
  end

  // Pointer moves just past the master that completed a handshake.
  always_comb begin
    rr_d = hs_s ? ID_W'((int'(sel_s) + 1) % N_MASTERS) : rr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= {ID_W{1'b0}};
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // While locked the earlier choice is held so req/payload stay stable until grant.
  assign sel_s = (state_q == ARB_LOCKED) ? sel_q : arb_pick_s;

  // Full is a registered flag: a same-cycle pop does not reopen the request path.
  assign s_req_o = any_req_s & ~fifo_full_s;
  assign hs_s    = s_req_o & s_gnt_i;

  // Payload mux; forced to zero when nobody is requesting.
  always_comb begin
    s_we_o    = any_req_s ? m_we_i[sel_s] : 1'b0;
    s_be_o    = any_req_s ? m_be_i[int'(sel_s)*OBI_BEW +: OBI_BEW] : {OBI_BEW{1'b0}};
    s_addr_o  = any_req_s ? m_addr_i[int'(sel_s)*OBI_AW +: OBI_AW] : {OBI_AW{1'b0}};
    s_wdata_o = any_req_s ? m_wdata_i[int'(sel_s)*OBI_DW +: OBI_DW] : {OBI_DW{1'b0}};
  end

  // A response is only routable if some transaction is outstanding.
  assign rsp_ok_s  = s_rvalid_i & ~fifo_empty_s;
  assign m_rdata_o = rsp_ok_s ? s_rdata_i : {OBI_DW{1'b0}};

  // One-hot grant and response-valid decode.
  always_comb begin
    m_gnt_o    = {N_MASTERS{1'b0}};
    m_rvalid_o = {N_MASTERS{1'b0}};
    for (int i = 0; i < N_MASTERS; i++) begin
      m_gnt_o[i]    = hs_s & (sel_s == ID_W'(i));
      m_rvalid_o[i] = rsp_ok_s & (fifo_head_s == ID_W'(i));
    end
  end

  // Lock state: enter on an ungranted request, leave on grant; idle cycles hold it.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ARB_FREE: begin
        if (s_req_o && !s_gnt_i) begin
          state_d = ARB_LOCKED;
          sel_d   = arb_pick_s;
        end else begin
          state_d = ARB_FREE;
        end
      end
      ARB_LOCKED: begin
        if (hs_s) begin
          state_d = ARB_FREE;
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d = ARB_FREE;
      end
    endcase
  end

  // Orphan responses set the error flag, which only reset clears.
  always_comb begin
    err_d = err_q | (s_rvalid_i & fifo_empty_s);
  end

  assign err_o = err_q;

  // Lock state, locked selection and error flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_FREE;
      sel_q   <= {ID_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  host_mem_arb_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (OUTST_DEPTH)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (hs_s),
    .push_id_i (sel_s),
    .pop_i     (s_rvalid_i),
    .head_o    (fifo_head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

endmodule : host_mem_arbiter

// File: tb/tb_host_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_host_mem_arbiter
// Directed bench for host_mem_arbiter (N_MASTERS=2, OUTST_DEPTH=2). Inputs are
// driven 1 time unit after the rising edge and outputs checked 1 unit later.
// Arbitration expectations follow HOST_MEM_ARB_FIXED_PRIO_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_host_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  m_req_i;
  logic [1:0]  m_we_i;
  logic [7:0]  m_be_i;
  logic [63:0] m_addr_i;
  logic [63:0] m_wdata_i;
  logic [1:0]  m_gnt_o;
  logic [1:0]  m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        s_req_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic        s_gnt_i;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_g [4];

  host_mem_arbiter #(
    .N_MASTERS   (2),
    .OUTST_DEPTH (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_req_i    (m_req_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m_req_i    = 2'b00;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
`ifdef HOST_MEM_ARB_FIXED_PRIO_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
    m_we_i    = 2'b00;
    m_be_i    = 8'hFF;
    m_addr_i  = {32'h0000_0200, 32'h0000_0100};
    m_wdata_i = {32'hCAFE_F00D, 32'h1234_5678};
    #1;
    do_reset();

    // Reset state, nobody requesting: everything quiet.
    #1;
    chk("rst_s_req", 32'(s_req_o), 32'd0);
    chk("rst_gnt", 32'(m_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(m_rvalid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_addr", s_addr_o, 32'h0);
    tick();

    // 1: single read from master0, one-cycle grant, response next cycle.
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    #1;
    chk("t1_s_req", 32'(s_req_o), 32'd1);
    chk("t1_addr", s_addr_o, 32'h0000_0100);
    chk("t1_we", 32'(s_we_o), 32'd0);
    chk("t1_gnt", 32'(m_gnt_o), 32'h1);
    tick();
    idle_inputs();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEAD_BEEF;
    #1;
    chk("t1_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("t1_rdata", m_rdata_o, 32'hDEAD_BEEF);
    tick();

    // 2: both request every cycle; slave grants immediately, answers one cycle later.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m_req_i    = 2'b11;
      s_gnt_i    = 1'b1;
      s_rvalid_i = (k > 0);
      s_rdata_i  = 32'hA000_0000 + 32'(k);
      #1;
      chk($sformatf("t2_gnt%0d", k), 32'(m_gnt_o), 32'(exp_g[k]));
      chk($sformatf("t2_rv%0d", k), 32'(m_rvalid_o), (k > 0) ? 32'(exp_g[k-1]) : 32'd0);
      tick();
    end
    idle_inputs();
    s_rvalid_i = 1'b1;
    #1;
    chk("t2_rv_last", 32'(m_rvalid_o), 32'(exp_g[3]));
    tick();

    // 3: master1 write waits 3 cycles for grant while master0 joins; payload must hold.
    idle_inputs();
    m_we_i  = 2'b10;
    m_be_i  = 8'h3F;
    m_req_i = 2'b10;
    #1;
    chk("t3_addr0", s_addr_o, 32'h0000_0200);
    chk("t3_gnt0", 32'(m_gnt_o), 32'd0);
    tick();
    m_req_i = 2'b11;
    for (int k = 1; k < 3; k++) begin
      #1;
      chk($sformatf("t3_addr%0d", k), s_addr_o, 32'h0000_0200);
      chk($sformatf("t3_gnt%0d", k), 32'(m_gnt_o), 32'd0);
      tick();
    end
    s_gnt_i = 1'b1;
    #1;
    chk("t3_gnt_final", 32'(m_gnt_o), 32'h2);
    chk("t3_addr_final", s_addr_o, 32'h0000_0200);
    chk("t3_we", 32'(s_we_o), 32'd1);
    chk("t3_be", 32'(s_be_o), 32'h3);
    chk("t3_wdata", s_wdata_o, 32'hCAFE_F00D);
    tick();
    idle_inputs();
    m_we_i     = 2'b00;
    m_be_i     = 8'hFF;
    s_rvalid_i = 1'b1;
    #1;
    chk("t3_rvalid", 32'(m_rvalid_o), 32'h2);
    tick();

    // 4: two grants with no responses fill the ID FIFO; third request is held off.
    idle_inputs();
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    #1;
    chk("t4_gnt_a", 32'(m_gnt_o), 32'h1);
    tick();
    #1;
    chk("t4_gnt_b", 32'(m_gnt_o), 32'h1);
    tick();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h1111_1111;
    #1;
    chk("t4_full_req", 32'(s_req_o), 32'd0);
    chk("t4_full_gnt", 32'(m_gnt_o), 32'd0);
    chk("t4_pop_rvalid", 32'(m_rvalid_o), 32'h1);
    tick();
    s_rvalid_i = 1'b0;
    #1;
    chk("t4_req_again", 32'(s_req_o), 32'd1);
    chk("t4_gnt_c", 32'(m_gnt_o), 32'h1);
    tick();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      s_rvalid_i = 1'b1;
      #1;
      chk($sformatf("t4_drain%0d", k), 32'(m_rvalid_o), 32'h1);
      tick();
    end

    // 5: response with nothing outstanding is dropped and sets the sticky error.
    idle_inputs();
    #1;
    chk("t5_err_before", 32'(err_o), 32'd0);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h5555_AAAA;
    #1;
    chk("t5_no_rvalid", 32'(m_rvalid_o), 32'd0);
    tick();
    s_rvalid_i = 1'b0;
    #1;
    chk("t5_err_set", 32'(err_o), 32'd1);
    tick();
    tick();
    chk("t5_err_sticky", 32'(err_o), 32'd1);
    do_reset();
    #1;
    chk("t5_err_cleared", 32'(err_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_host_mem_arbiter
